// File: rtl/tt_pkg.sv
// tt_pkg: shared definitions for the truth-table sweep/capture block.
//   N_IN_DEF / TT_W_DEF : default FUT input count and truth-table width.
//   tt_state_e          : sweep controller states.
//   tt_idx_t            : truth-table index at the default width.
package tt_pkg;

   localparam int N_IN_DEF = 7;
   localparam int TT_W_DEF = 2 ** N_IN_DEF;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DRAIN,
      HOLD
   } tt_state_e;

   typedef logic [N_IN_DEF-1:0] tt_idx_t;

endpackage

// File: rtl/tt_delay_pipe.sv
// tt_delay_pipe: LAT-stage register pipe carrying {valid, index} alongside
// each vector issued to the function-under-test, so the capture side knows
// which truth-table bit the FUT response belongs to. LAT = 0 is a
// wire-through.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (clears every stage)
//   in_valid   an index is being issued this cycle
//   in_idx     issued index
//   out_valid  delayed valid
//   out_idx    delayed index
module tt_delay_pipe
   import tt_pkg::*;
#(
   parameter int IDX_W = N_IN_DEF,
   parameter int LAT   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx
);

   if (LAT == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_idx   = in_idx;
      // clock and reset have no load in the wire-through build
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
   end else begin : g_regs
      logic             v   [LAT];
      logic [IDX_W-1:0] idx [LAT];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int unsigned k = 0; k < unsigned'(LAT); k++) begin
               v[k]   <= 1'b0;
               idx[k] <= '0;
            end
         end else begin
            v[0]   <= in_valid;
            idx[0] <= in_idx;
            for (int unsigned k = 1; k < unsigned'(LAT); k++) begin
               v[k]   <= v[k-1];
               idx[k] <= idx[k-1];
            end
         end
      end

      assign out_valid = v[LAT-1];
      assign out_idx   = idx[LAT-1];
   end

endmodule

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps all 2^N_IN input vectors into a combinational
// (or LAT-cycle pipelined) function-under-test and collects its response
// into a 2^N_IN-bit truth table, bit i = f(x == i), offered on a
// valid/ready interface.
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset; aborts any sweep
//   start_i     one-cycle sweep request, honoured only when idle
//   busy_o      high while sweeping or draining the FUT pipe
//   x_o         input vector to the FUT (x_o[k] drives FUT input xk)
//   f_i         FUT output, LAT cycles after the matching x_o
//   tt_o        captured truth table
//   tt_valid_o  truth table available
//   tt_ready_i  consumer accepts tt_o
//   onset_o     number of captured 1s (only with TT_ONSET_COUNT_EN)
// Optional feature macro: TT_ONSET_COUNT_EN adds the onset_o counter port.
module tt_sweep_capture
   import tt_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int LAT  = 0,
   localparam int TT_W = 2 ** N_IN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   output logic            busy_o,
   output logic [N_IN-1:0] x_o,
   input  logic            f_i,
   output logic [TT_W-1:0] tt_o,
   output logic            tt_valid_o,
   input  logic            tt_ready_i
`ifdef TT_ONSET_COUNT_EN
   ,
   output logic [N_IN:0]   onset_o
`endif
);

   localparam logic [N_IN:0]   LAST_CNT = (N_IN+1)'(TT_W - 1);
   localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

   tt_state_e       state;
   logic [N_IN:0]   cnt;
   logic            issue;
   logic            cap_valid;
   logic [N_IN-1:0] cap_idx;

   // x_o is the low part of the registered issue counter, so it naturally
   // holds its last value in DRAIN, HOLD and IDLE.
   assign x_o   = cnt[N_IN-1:0];
   assign issue = (state == SWEEP);

   tt_delay_pipe #(
      .IDX_W (N_IN),
      .LAT   (LAT)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (issue),
      .in_idx    (x_o),
      .out_valid (cap_valid),
      .out_idx   (cap_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         tt_o       <= '0;
         tt_valid_o <= 1'b0;
         busy_o     <= 1'b0;
`ifdef TT_ONSET_COUNT_EN
         onset_o    <= '0;
`endif
      end else begin
         // Capture runs independently of the state; the pipe is always
         // empty in IDLE, so the clear on SWEEP entry below cannot collide.
         if (cap_valid) begin
            tt_o[cap_idx] <= f_i;
`ifdef TT_ONSET_COUNT_EN
            onset_o <= onset_o + (N_IN+1)'(f_i);
`endif
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  state  <= SWEEP;
                  cnt    <= '0;
                  tt_o   <= '0;
                  busy_o <= 1'b1;
`ifdef TT_ONSET_COUNT_EN
                  onset_o <= '0;
`endif
               end
            end
            SWEEP: begin
               if (cnt == LAST_CNT) begin
                  if (LAT > 0) begin
                     state <= DRAIN;
                  end else begin
                     // last capture happens on this same edge
                     state      <= HOLD;
                     busy_o     <= 1'b0;
                     tt_valid_o <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               // exactly LAT cycles: ends when the last index is captured
               if (cap_valid && (cap_idx == LAST_IDX)) begin
                  state      <= HOLD;
                  busy_o     <= 1'b0;
                  tt_valid_o <= 1'b1;
               end
            end
            HOLD: begin
               if (tt_ready_i) begin
                  state      <= IDLE;
                  tt_valid_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: directed bench for tt_sweep_capture. dut0 uses
// LAT=0 with a selectable combinational FUT; dut2 uses LAT=2 with a FUT
// that registers x6 twice.
module tb_tt_sweep_capture;
   import tt_pkg::*;

   localparam logic [TT_W_DEF-1:0] TT_MAJ = {16{8'hE8}};
   localparam logic [TT_W_DEF-1:0] TT_X6  = {{64{1'b1}}, {64{1'b0}}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic                start0 = 1'b0, rdy0 = 1'b0, f0, busy0, v0;
   tt_idx_t             x0;
   logic [TT_W_DEF-1:0] tt0;
   logic                start2 = 1'b0, rdy2 = 1'b0, f2, busy2, v2;
   tt_idx_t             x2;
   logic [TT_W_DEF-1:0] tt2;
`ifdef TT_ONSET_COUNT_EN
   logic [N_IN_DEF:0]   onset0, onset2;
`endif

   logic [1:0] fsel = 2'd0;   // 0: maj(x0,x1,x2)  1: const 0  2: const 1
   logic       r1, r2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb begin
      f0 = 1'b1;
      case (fsel)
         2'd0: f0 = (x0[0] & x0[1]) | (x0[0] & x0[2]) | (x0[1] & x0[2]);
         2'd1: f0 = 1'b0;
         default: f0 = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      r1 <= x2[6];
      r2 <= r1;
   end
   assign f2 = r2;

   tt_sweep_capture #(.N_IN(7), .LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(start0), .busy_o(busy0), .x_o(x0),
      .f_i(f0), .tt_o(tt0), .tt_valid_o(v0), .tt_ready_i(rdy0)
`ifdef TT_ONSET_COUNT_EN
      , .onset_o(onset0)
`endif
   );

   tt_sweep_capture #(.N_IN(7), .LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_i(start2), .busy_o(busy2), .x_o(x2),
      .f_i(f2), .tt_o(tt2), .tt_valid_o(v2), .tt_ready_i(rdy2)
`ifdef TT_ONSET_COUNT_EN
      , .onset_o(onset2)
`endif
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
      total++; if (x0 !== 7'd0) begin bad++; $display("FAIL reset_x0 got=%0d exp=0", x0); end
      total++; if (tt0 !== '0) begin bad++; $display("FAIL reset_tt0 got=%h exp=0", tt0); end
      total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b exp=0", v0); end
      total++; if ({busy2, v2, x2} !== 9'd0) begin bad++; $display("FAIL reset_dut2 got=%b exp=0", {busy2, v2, x2}); end
      total++; if (tt2 !== '0) begin bad++; $display("FAIL reset_tt2 got=%h exp=0", tt2); end
`ifdef TT_ONSET_COUNT_EN
      total++; if (onset0 !== 8'd0) begin bad++; $display("FAIL reset_onset0 got=%0d exp=0", onset0); end
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // leaves dut0 in HOLD for the backpressure test
   task automatic test_maj();
      int n;
      fsel = 2'd0; rdy0 = 1'b0;
      start0 = 1'b1;
      @(posedge clk); #1;          // edge 0 sampled start; now in cycle 1
      start0 = 1'b0;
      total++; if (busy0 !== 1'b1 || x0 !== 7'd0) begin bad++; $display("FAIL maj_first_issue got busy=%b x=%0d exp busy=1 x=0", busy0, x0); end
      n = 1;
      while (v0 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (n !== 129) begin bad++; $display("FAIL maj_valid_cycle got=%0d exp=129", n); end
      total++; if (tt0 !== TT_MAJ) begin bad++; $display("FAIL maj_table got=%h exp=%h", tt0, TT_MAJ); end
      total++; if (busy0 !== 1'b0 || x0 !== 7'd127) begin bad++; $display("FAIL maj_hold_state got busy=%b x=%0d exp busy=0 x=127", busy0, x0); end
`ifdef TT_ONSET_COUNT_EN
      total++; if (onset0 !== 8'd64) begin bad++; $display("FAIL maj_onset got=%0d exp=64", onset0); end
`endif
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 10; i++) begin
         start0 = (i == 4);
         @(posedge clk); #1;
         total++; if (v0 !== 1'b1 || busy0 !== 1'b0 || tt0 !== TT_MAJ) begin
            bad++; $display("FAIL bp_hold_%0d got valid=%b busy=%b tt=%h exp valid=1 busy=0 tt=%h", i, v0, busy0, tt0, TT_MAJ);
         end
      end
      start0 = 1'b0;
      rdy0 = 1'b1;
      @(posedge clk); #1;
      rdy0 = 1'b0;
      total++; if (v0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL bp_accept got valid=%b busy=%b exp 0 0", v0, busy0); end
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy0 !== 1'b0 || x0 !== 7'd127) begin bad++; $display("FAIL bp_idle_after got busy=%b x=%0d exp busy=0 x=127", busy0, x0); end
   endtask

   task automatic test_lat2();
      int n;
      rdy2 = 1'b0;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 1;
      while (v2 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (n !== 131) begin bad++; $display("FAIL lat2_valid_cycle got=%0d exp=131", n); end
      total++; if (tt2 !== TT_X6) begin bad++; $display("FAIL lat2_table got=%h exp=%h", tt2, TT_X6); end
`ifdef TT_ONSET_COUNT_EN
      total++; if (onset2 !== 8'd64) begin bad++; $display("FAIL lat2_onset got=%0d exp=64", onset2); end
`endif
      rdy2 = 1'b1;
      @(posedge clk); #1;
      rdy2 = 1'b0;
      total++; if (v2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL lat2_accept got valid=%b busy=%b exp 0 0", v2, busy2); end
   endtask

   task automatic test_reset_mid();
      int n;
      fsel = 2'd0; rdy0 = 1'b0;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (x0 !== 7'd50 && n < 200) begin @(posedge clk); #1; n++; end
      total++; if (x0 !== 7'd50) begin bad++; $display("FAIL rstmid_reach50 got=%0d exp=50", x0); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++; if (busy0 !== 1'b0 || v0 !== 1'b0 || x0 !== 7'd0) begin
         bad++; $display("FAIL rstmid_state got busy=%b valid=%b x=%0d exp 0 0 0", busy0, v0, x0);
      end
      total++; if (tt0 !== '0) begin bad++; $display("FAIL rstmid_tt got=%h exp=0", tt0); end
      @(posedge clk); #1;
      total++; if (busy0 !== 1'b0 || v0 !== 1'b0) begin bad++; $display("FAIL rstmid_still_idle got busy=%b valid=%b exp 0 0", busy0, v0); end
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 1;
      while (v0 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (n !== 129 || tt0 !== TT_MAJ) begin bad++; $display("FAIL rstmid_fresh got cycle=%0d tt=%h exp cycle=129 tt=%h", n, tt0, TT_MAJ); end
      rdy0 = 1'b1;
      @(posedge clk); #1;
      rdy0 = 1'b0;
   endtask

   task automatic test_start_in_sweep();
      int n;
      fsel = 2'd0; rdy0 = 1'b0;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (x0 !== 7'd20 && n < 200) begin @(posedge clk); #1; n++; end
      total++; if (x0 !== 7'd20) begin bad++; $display("FAIL sweepstart_reach20 got=%0d exp=20", x0); end
      start0 = 1'b1;
      for (int k = 21; k <= 23; k++) begin
         @(posedge clk); #1;
         start0 = 1'b0;
         total++; if (x0 !== 7'(k) || busy0 !== 1'b1) begin bad++; $display("FAIL sweepstart_x%0d got x=%0d busy=%b exp x=%0d busy=1", k, x0, busy0, k); end
      end
      n = 0;
      while (v0 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (tt0 !== TT_MAJ) begin bad++; $display("FAIL sweepstart_table got=%h exp=%h", tt0, TT_MAJ); end
      rdy0 = 1'b1;
      @(posedge clk); #1;
      rdy0 = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      rdy0 = 1'b1;
      // sweep 1: f = 0
      fsel = 2'd1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (v0 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (v0 !== 1'b1 || tt0 !== '0) begin bad++; $display("FAIL b2b_zero got valid=%b tt=%h exp valid=1 tt=0", v0, tt0); end
      // sweep 2: f = 1; start held across the HOLD->IDLE edge
      fsel = 2'd2;
      start0 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (v0 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (v0 !== 1'b1 || tt0 !== {TT_W_DEF{1'b1}}) begin bad++; $display("FAIL b2b_ones got valid=%b tt=%h exp valid=1 tt=all ones", v0, tt0); end
`ifdef TT_ONSET_COUNT_EN
      total++; if (onset0 !== 8'd128) begin bad++; $display("FAIL b2b_onset got=%0d exp=128", onset0); end
`endif
      // sweep 3: f = 0 again; old ones must be gone as soon as the sweep starts
      fsel = 2'd1;
      start0 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++; if (busy0 !== 1'b1 || tt0 !== '0) begin bad++; $display("FAIL b2b_cleared got busy=%b tt=%h exp busy=1 tt=0", busy0, tt0); end
      n = 0;
      while (v0 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (v0 !== 1'b1 || tt0 !== '0) begin bad++; $display("FAIL b2b_zero2 got valid=%b tt=%h exp valid=1 tt=0", v0, tt0); end
      @(posedge clk); #1;
      rdy0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_maj();
      test_backpressure();
      test_lat2();
      test_reset_mid();
      test_start_in_sweep();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
